// File: rtl/bsm_pkg.sv
// Shared types and the per-bit update for the signed bit-serial multiplier.
// The update uses only shifts and adds, so no parallel multiplier is inferred.
package bsm_pkg;

    localparam int OUT_W = 32;
    localparam int MAX_W = 16;

    typedef logic [4:0]              width_t;
    typedef logic signed [OUT_W-1:0] acc_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        acc_t a;
        acc_t b;
        acc_t p;
    } step_t;

    function automatic acc_t signed_pow2(input logic [5:0] sh, input logic neg);
        acc_t v;
        v = acc_t'(1) <<< sh;
        return neg ? -v : v;
    endfunction

    // Adds bit k of each operand: P += a*w*B(k-1) + b*w'*A(k-1) + a*b*w*w'.
    // The top bit of an operand carries negative weight; later bits are ignored.
    function automatic step_t bsm_step(input step_t  cur,
                                       input logic   a_bit,
                                       input logic   b_bit,
                                       input width_t k,
                                       input width_t wa,
                                       input width_t wb);
        step_t nxt;
        logic  a_en;
        logic  b_en;
        logic  a_neg;
        logic  b_neg;
        acc_t  a_sh;
        acc_t  b_sh;
        a_en  = a_bit && (k < wa);
        b_en  = b_bit && (k < wb);
        a_neg = (k == wa - 5'd1);
        b_neg = (k == wb - 5'd1);
        a_sh  = cur.a <<< k;
        b_sh  = cur.b <<< k;
        nxt   = cur;
        if (a_en) begin
            nxt.a = cur.a + signed_pow2({1'b0, k}, a_neg);
            nxt.p = nxt.p + (a_neg ? -b_sh : b_sh);
        end
        if (b_en) begin
            nxt.b = cur.b + signed_pow2({1'b0, k}, b_neg);
            nxt.p = nxt.p + (b_neg ? -a_sh : a_sh);
        end
        if (a_en && b_en) begin
            nxt.p = nxt.p + signed_pow2({k, 1'b0}, a_neg ^ b_neg);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bit_serial_mult.sv
// Signed bit-serial multiplier: operands arrive LSB first, one bit per clock,
// and the 32-bit product is presented with a one-cycle done pulse.
module bit_serial_mult
    import bsm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        WA,
    input  logic [4:0]        WB,
    input  logic              bitAin,
    input  logic              bitBin,
    output logic signed [31:0] O,
    output logic              done
);

    state_t state_q;
    state_t state_d;
    width_t wa_q;
    width_t wb_q;
    width_t n_q;
    width_t k_q;
    step_t  acc_q;
    step_t  acc_d;
    logic   last_bit;

    assign acc_d    = bsm_step(acc_q, bitAin, bitBin, k_q, wa_q, wb_q);
    assign last_bit = (k_q == n_q - 5'd1);
    assign done     = (state_q == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     if (last_bit) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // start wins over RUN, so a re-issued start aborts without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wa_q  <= '0;
            wb_q  <= '0;
            n_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            O     <= '0;
        end else if (start) begin
            wa_q  <= WA;
            wb_q  <= WB;
            n_q   <= (WA > WB) ? WA : WB;
            k_q   <= '0;
            acc_q <= '0;
        end else if (state_q == RUN) begin
            acc_q <= acc_d;
            k_q   <= k_q + 5'd1;
            if (last_bit) begin
                O <= acc_d.p;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_mult.sv
// Directed and back-to-back checks for bit_serial_mult; inputs change and
// outputs are sampled on the falling edge.
module tb_bit_serial_mult;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [4:0]         WA;
    logic [4:0]         WB;
    logic               bitAin;
    logic               bitBin;
    logic signed [31:0] O;
    logic               done;

    int n_vec = 0;
    int n_err = 0;

    bit_serial_mult dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .WA     (WA),
        .WB     (WB),
        .bitAin (bitAin),
        .bitBin (bitBin),
        .O      (O),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a multiply and feed only nbits bits, leaving the run unfinished.
    task automatic partial(input int a, input int b, input logic [4:0] wa,
                           input logic [4:0] wb, input int nbits);
        logic signed [31:0] av;
        logic signed [31:0] bv;
        av     = a;
        bv     = b;
        start  = 1'b1;
        WA     = wa;
        WB     = wb;
        bitAin = 1'b1;
        bitBin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < nbits; k++) begin
            bitAin = av[k];
            bitBin = bv[k];
            @(negedge clk);
        end
    endtask

    // Full multiply: done must stay low for N cycles, then pulse with O valid.
    task automatic run_mult(input string tag, input int a, input int b,
                            input logic [4:0] wa, input logic [4:0] wb,
                            input int exp);
        logic signed [31:0] av;
        logic signed [31:0] bv;
        int                 n;
        logic               early;
        av     = a;
        bv     = b;
        n      = (wa > wb) ? int'(wa) : int'(wb);
        early  = 1'b0;
        start  = 1'b1;
        WA     = wa;
        WB     = wb;
        bitAin = 1'b1;
        bitBin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            early  = early | done;
            bitAin = av[k];
            bitBin = bv[k];
            @(negedge clk);
        end
        check({tag, "_early_done"}, 32'(early), 32'sd0);
        check({tag, "_done"}, 32'(done), 32'sd1);
        check({tag, "_O"}, O, exp);
    endtask

    initial begin
        int ra;
        int rb;
        rst    = 1'b1;
        start  = 1'b0;
        WA     = 5'd8;
        WB     = 5'd7;
        bitAin = 1'b0;
        bitBin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_O", O, 32'sd0);
        check("reset_done", 32'(done), 32'sd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_done", 32'(done), 32'sd0);

        run_mult("w8x7_15_m7", 15, -7, 5'd8, 5'd7, -105);
        @(negedge clk);
        check("pulse_one_cycle", 32'(done), 32'sd0);
        check("O_holds", O, -32'sd105);

        run_mult("w8x7_m128_m64", -128, -64, 5'd8, 5'd7, 8192);
        run_mult("w8x7_127_63", 127, 63, 5'd8, 5'd7, 8001);
        run_mult("w8x7_0_m5", 0, -5, 5'd8, 5'd7, 0);
        run_mult("w16_min_min", -32768, -32768, 5'd16, 5'd16, 1073741824);
        run_mult("w16_max_min", 32767, -32768, 5'd16, 5'd16, -1073709056);
        run_mult("w2x2_m2_m2", -2, -2, 5'd2, 5'd2, 4);
        run_mult("w3x16_m1_m1", -1, -1, 5'd3, 5'd16, 1);

        // Back-to-back: each new start lands in the done cycle of the last run.
        for (int i = 0; i < 1000; i++) begin
            ra = int'($urandom_range(126)) - 63;
            rb = int'($urandom_range(62)) - 31;
            run_mult("b2b", ra, rb, 5'd8, 5'd7, ra * rb);
        end

        // Abort: restart at E4, the aborted run must not raise done.
        partial(100, 50, 5'd8, 5'd7, 3);
        check("abort_no_done", 32'(done), 32'sd0);
        run_mult("after_abort", -37, 23, 5'd8, 5'd7, -851);

        // Asynchronous reset in the middle of a run.
        partial(-300, 77, 5'd12, 5'd9, 5);
        rst = 1'b1;
        #1;
        check("midrun_rst_O", O, 32'sd0);
        check("midrun_rst_done", 32'(done), 32'sd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_mult("after_rst", -300, 77, 5'd12, 5'd9, -23100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
